bus_rr_arbiter: RTL and testbench

Round-robin arbiter sharing one 32-bit datapath resource among eight requesters. It sequences ownership of the shared port and drives the 3-bit select of the 8:1 32-bit datapath mux in front of that resource, plus a one-hot grant back to the requesters. Grants are held until the resource signals completion, the owner withdraws its request, or a watchdog timeout fires.

---
 rtl/bus_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_bus_rr_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin owner sequencing for one shared 32-bit resource
// among eight requesters. Drives a one-hot grant back to the requesters and a
// binary select for the 8:1 datapath mux in front of the resource. Ownership is
// held until the resource pulses done, the owner drops its request, or the
// watchdog expires.
module bus_rr_arbiter #(
  parameter int unsigned TIMEOUT = 255  // max cycles a grant may be held without done; 0 disables
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  // Counter is at least one bit wide so TIMEOUT=0 still elaborates cleanly.
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Expiry is judged on the count sampled at the edge, so the last count value
  // before release is TIMEOUT-1; this lands the pulse exactly T edges after the grant.
  localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t        state;
  logic [2:0]    last;     // most recent owner; lowest priority in the next search
  logic [CW-1:0] wd_cnt;

  logic [2:0] owner;
  logic [7:0] others;
  logic [2:0] idle_pick;
  logic [2:0] own_pick;
  logic       wd_expire;
  logic       rel_any;
  logic       rel_to;

  // First set bit of r searching from ptr+1 upward, wrapping modulo 8, so ptr
  // itself is visited last. Caller guarantees r is nonzero when the result is used.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    logic [2:0] pick;
    pick  = ptr;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Release detection and next-owner selection for the current cycle.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path first, so no latch is inferred.
    owner     = sel;
    others    = req & ~(8'b1 << sel);
    idle_pick = rr_pick(req, last);
    own_pick  = rr_pick(others, sel);
    wd_expire = 1'b0;
    rel_any   = 1'b0;
    rel_to    = 1'b0;
    if (state == OWN) begin
      wd_expire = (TIMEOUT > 0) && (wd_cnt == WD_LAST);
      rel_any   = done || !req[owner] || wd_expire;
      // done wins over expiry, and an owner that has already let go is not
      // reported as a timeout.
      rel_to    = wd_expire && !done && req[owner];
    end
  end

  // Ownership state machine with registered grant, select, busy and timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      last    <= 3'd7;
      wd_cnt  <= '0;
    end else begin
      timeout <= rel_to;
      case (state)
        IDLE: begin
          if (|req) begin
            state  <= OWN;
            gnt    <= 8'b1 << idle_pick;
            sel    <= idle_pick;
            last   <= idle_pick;
            busy   <= 1'b1;
            wd_cnt <= '0;
          end
        end
        OWN: begin
          if (rel_any) begin
            if (|others) begin
              // Back-to-back handover: no idle bubble between owners.
              gnt    <= 8'b1 << own_pick;
              sel    <= own_pick;
              last   <= own_pick;
              wd_cnt <= '0;
            end else if (req[owner] && done) begin
              // Sole requester finished a transaction and wants another.
              wd_cnt <= '0;
            end else begin
              // sel and last keep the old owner so the mux stays stable.
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
            end
          end else if ((TIMEOUT > 0) && (wd_cnt < WD_MAX)) begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: scenario tasks drive req/done one cycle at a time, push the
// hand-derived expected outputs onto a scoreboard queue, and pop/compare after
// the edge that produces them. The DUT runs with TIMEOUT=4.
module tb_bus_rr_arbiter;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       tmo;
  } out_t;

  typedef struct packed {
    logic [7:0] req;
    logic       done;
    out_t       exp;
  } row_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  out_t obs;
  out_t sb[$];
  int   vectors;
  int   miscompares;

  assign obs = {gnt, sel, busy, timeout};

  bus_rr_arbiter #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything stalls the sequence.
  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation exceeded 200000 time units, required completion");
    $fatal(1);
  end

  function automatic row_t r(input logic [7:0] rq, input logic dn, input logic [7:0] g,
                             input logic [2:0] s, input logic b, input logic t);
    return {rq, dn, g, s, b, t};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Apply one row's inputs for one cycle and queue its expected outputs.
  task automatic drive(input row_t rw);
    @(negedge clk);
    req  = rw.req;
    done = rw.done;
    sb.push_back(rw.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows [5];
    out_t e;
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    #12;
    sb.push_back(out_t'({8'h00, 3'd0, 1'b0, 1'b0}));
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL reset_hold: gnt=%h sel=%0d busy=%b timeout=%b, expected gnt=%h sel=%0d busy=%b timeout=%b",
               obs.gnt, obs.sel, obs.busy, obs.tmo, e.gnt, e.sel, e.busy, e.tmo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rows = '{r(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0),
             r(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0),
             r(8'h00, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0),
             r(8'h00, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0),
             r(8'h00, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0)};
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset_single[%0d]: gnt=%h sel=%0d busy=%b timeout=%b, expected gnt=%h sel=%0d busy=%b timeout=%b",
                 i, obs.gnt, obs.sel, obs.busy, obs.tmo, e.gnt, e.sel, e.busy, e.tmo);
      end
    end
  endtask

  task automatic test_round_robin();
    row_t rows [10];
    out_t e;
    do_reset();
    rows[0] = r(8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      rows[k] = r(8'hFF, 1'b1, 8'b1 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
    end
    rows[9] = r(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL round_robin[%0d]: gnt=%h sel=%0d busy=%b timeout=%b, expected gnt=%h sel=%0d busy=%b timeout=%b",
                 i, obs.gnt, obs.sel, obs.busy, obs.tmo, e.gnt, e.sel, e.busy, e.tmo);
      end
    end
  endtask

  task automatic test_priority_after_owner();
    row_t rows [5];
    out_t e;
    do_reset();
    rows = '{r(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0),
             r(8'h00, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0),
             r(8'h21, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0),
             r(8'h21, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0),
             r(8'h00, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0)};
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL priority_after_owner[%0d]: gnt=%h sel=%0d busy=%b timeout=%b, expected gnt=%h sel=%0d busy=%b timeout=%b",
                 i, obs.gnt, obs.sel, obs.busy, obs.tmo, e.gnt, e.sel, e.busy, e.tmo);
      end
    end
  endtask

  task automatic test_owner_withdrawal();
    row_t rows [5];
    out_t e;
    do_reset();
    rows = '{r(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0),
             r(8'h48, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0),
             r(8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0),
             r(8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0),
             r(8'h00, 1'b0, 8'h00, 3'd6, 1'b0, 1'b0)};
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL owner_withdrawal[%0d]: gnt=%h sel=%0d busy=%b timeout=%b, expected gnt=%h sel=%0d busy=%b timeout=%b",
                 i, obs.gnt, obs.sel, obs.busy, obs.tmo, e.gnt, e.sel, e.busy, e.tmo);
      end
    end
  endtask

  task automatic test_watchdog();
    row_t rows [18];
    out_t e;
    do_reset();
    rows = '{
      // sole requester 2 times out after 4 edges, drops to idle, then is re-granted
      r(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0),
      r(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0),
      r(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0),
      r(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0),
      r(8'h04, 1'b0, 8'h00, 3'd2, 1'b0, 1'b1),
      r(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0),
      // with requester 5 waiting, expiry hands over directly
      r(8'h24, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0),
      r(8'h24, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0),
      r(8'h24, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0),
      r(8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b1),
      r(8'h00, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0),
      // done on the expiry edge: no pulse, re-grant to 2, counter restarts
      r(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0),
      r(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0),
      r(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0),
      r(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0),
      r(8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0),
      r(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0),
      r(8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0)};
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL watchdog[%0d]: gnt=%h sel=%0d busy=%b timeout=%b, expected gnt=%h sel=%0d busy=%b timeout=%b",
                 i, obs.gnt, obs.sel, obs.busy, obs.tmo, e.gnt, e.sel, e.busy, e.tmo);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    row_t pre [1];
    row_t post [3];
    out_t e;
    do_reset();
    pre = '{r(8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0)};
    foreach (pre[i]) begin
      drive(pre[i]);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL mid_grant_setup[%0d]: gnt=%h sel=%0d busy=%b timeout=%b, expected gnt=%h sel=%0d busy=%b timeout=%b",
                 i, obs.gnt, obs.sel, obs.busy, obs.tmo, e.gnt, e.sel, e.busy, e.tmo);
      end
    end
    // Assert reset between clock edges and look before the next edge arrives.
    #2;
    rst_n = 1'b0;
    req   = 8'h81;
    sb.push_back(out_t'({8'h00, 3'd0, 1'b0, 1'b0}));
    #1;
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL async_reset: gnt=%h sel=%0d busy=%b timeout=%b, expected gnt=%h sel=%0d busy=%b timeout=%b",
               obs.gnt, obs.sel, obs.busy, obs.tmo, e.gnt, e.sel, e.busy, e.tmo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    post = '{r(8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0),
             r(8'h80, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0),
             r(8'h00, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0)};
    foreach (post[i]) begin
      drive(post[i]);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL after_async_reset[%0d]: gnt=%h sel=%0d busy=%b timeout=%b, expected gnt=%h sel=%0d busy=%b timeout=%b",
                 i, obs.gnt, obs.sel, obs.busy, obs.tmo, e.gnt, e.sel, e.busy, e.tmo);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req         = 8'h00;
    done        = 1'b0;
    test_reset();
    test_round_robin();
    test_priority_after_owner();
    test_owner_withdrawal();
    test_watchdog();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
